// File: rtl/wfg_stim_mem_core.sv
// Stimulus memory sample sequencer: walks START..END by INC, reads one SRAM
// word per step and presents it on an AXI-Stream style output.
module wfg_stim_mem_core #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ctrl_en_i,
  input  logic [15:0]       start_val_i,
  input  logic [15:0]       end_val_i,
  input  logic [7:0]        inc_val_i,
  output logic              mem_cs_o,
  output logic [15:0]       mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              wfg_axis_tready_i,
  output logic              wfg_axis_tvalid_o,
  output logic [DATA_W-1:0] wfg_axis_tdata_o,
  output logic              wrap_o
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned SUM_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    CAPT  = 2'd2,
    VALID = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   tdata_q, tdata_d;
  logic                tvalid_q, tvalid_d;

  logic [SUM_W-1:0]    sum;
  logic                wrap_c;
  logic [ADDR_W-1:0]   next_addr;
  logic                handshake;

  // Next address; the 17-bit sum catches overshoot past 0xFFFF as a wrap.
  always_comb begin
    sum       = {1'b0, addr_q} + SUM_W'(inc_val_i);
    wrap_c    = (sum > {1'b0, end_val_i});
    next_addr = wrap_c ? start_val_i : sum[ADDR_W-1:0];
    handshake = (state_q == VALID) && tvalid_q && wfg_axis_tready_i;
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;

    // Disable wins over everything, including a same-cycle handshake.
    if (!ctrl_en_i) begin
      state_d  = IDLE;
      tvalid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          addr_d  = start_val_i;
          state_d = READ;
        end
        READ: begin
          state_d = CAPT;
        end
        CAPT: begin
          tdata_d  = mem_rdata_i;
          tvalid_d = 1'b1;
          state_d  = VALID;
        end
        VALID: begin
          if (handshake) begin
            tvalid_d = 1'b0;
            addr_d   = next_addr;
            state_d  = READ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign mem_cs_o          = (state_q == READ);
  assign mem_addr_o        = mem_cs_o ? addr_q : '0;
  assign wrap_o            = handshake && ctrl_en_i && wrap_c;
  assign wfg_axis_tvalid_o = tvalid_q;
  assign wfg_axis_tdata_o  = tdata_q;

endmodule

// File: tb/tb_wfg_stim_mem_core.sv
// Self-checking bench for wfg_stim_mem_core: table of configurations with a
// read/sample scoreboard, plus hand sequences for backpressure, disable, reset.
module tb_wfg_stim_mem_core;

  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [15:0]       start_val, end_val;
  logic [7:0]        inc_val;
  logic              mem_cs;
  logic [15:0]       mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              tready;
  logic              tvalid;
  logic [DATA_W-1:0] tdata;
  logic              wrap;

  int n_tests = 0;
  int n_fail  = 0;

  wfg_stim_mem_core #(.DATA_W(DATA_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ctrl_en_i         (en),
    .start_val_i       (start_val),
    .end_val_i         (end_val),
    .inc_val_i         (inc_val),
    .mem_cs_o          (mem_cs),
    .mem_addr_o        (mem_addr),
    .mem_rdata_i       (mem_rdata),
    .wfg_axis_tready_i (tready),
    .wfg_axis_tvalid_o (tvalid),
    .wfg_axis_tdata_o  (tdata),
    .wrap_o            (wrap)
  );

  always #5 clk = ~clk;

  // SRAM model: data one cycle after the strobe, garbage otherwise.
  always_ff @(posedge clk) begin
    if (mem_cs) mem_rdata <= 32'hA000 + 32'(mem_addr);
    else        mem_rdata <= 32'hDEAD_BEEF;
  end

  typedef struct {
    logic [15:0]      start;
    logic [15:0]      endv;
    logic [7:0]       inc;
    logic [4:0][15:0] a;
    logic [3:0]       w;
  } vec_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              wrap;
  } samp_t;

  logic [15:0] addr_exp[$];
  samp_t       samp_exp[$];
  int          cyc, last_hs, nhs;

  function automatic vec_t mk(input logic [15:0] s, input logic [15:0] e, input logic [7:0] i,
                              input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                              input logic [15:0] a3, input logic [15:0] a4,
                              input logic w0, input logic w1, input logic w2, input logic w3);
    vec_t v;
    v.start = s; v.endv = e; v.inc = i;
    v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3; v.a[4] = a4;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: unexpected event at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after each edge, before inputs change.
  task automatic mon();
    samp_t s;
    if (mem_cs) begin
      if (addr_exp.size() == 0) fail("extra_read");
      else chk("rd_addr", 64'(mem_addr), 64'(addr_exp.pop_front()));
    end
    if (tvalid && tready && en) begin
      if (samp_exp.size() == 0) fail("extra_sample");
      else begin
        s = samp_exp.pop_front();
        chk("tdata", 64'(tdata), 64'(s.data));
        chk("wrap", 64'(wrap), 64'(s.wrap));
      end
      if (nhs > 0) chk("sample_gap", 64'(cyc - last_hs), 64'd3);
      last_hs = cyc;
      nhs++;
    end else if (wrap) begin
      fail("spurious_wrap");
    end
  endtask

  vec_t vecs[8];

  initial begin
    samp_t s;
    vecs[0] = mk(16'd0,      16'd8,      8'd4,    16'd0, 16'd4, 16'd8, 16'd0, 16'd4, 0, 0, 1, 0);
    vecs[1] = mk(16'd2,      16'd9,      8'd3,    16'd2, 16'd5, 16'd8, 16'd2, 16'd5, 0, 0, 1, 0);
    vecs[2] = mk(16'd5,      16'd3,      8'd1,    16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 1, 1, 1, 1);
    vecs[3] = mk(16'd7,      16'd7,      8'd0,    16'd7, 16'd7, 16'd7, 16'd7, 16'd7, 0, 0, 0, 0);
    vecs[4] = mk(16'd7,      16'd7,      8'd1,    16'd7, 16'd7, 16'd7, 16'd7, 16'd7, 1, 1, 1, 1);
    vecs[5] = mk(16'hFFF0,   16'hFFFF,   8'hFF,   16'hFFF0, 16'hFFF0, 16'hFFF0, 16'hFFF0, 16'hFFF0, 1, 1, 1, 1);
    vecs[6] = mk(16'hFFFE,   16'hFFFF,   8'd1,    16'hFFFE, 16'hFFFF, 16'hFFFE, 16'hFFFF, 16'hFFFE, 0, 1, 0, 1);
    vecs[7] = mk(16'd9,      16'd4,      8'd0,    16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 1, 1, 1, 1);

    rst_n = 1'b0; en = 1'b0; tready = 1'b0;
    start_val = 16'd0; end_val = 16'd8; inc_val = 8'd4;
    #12;
    chk("reset_cs", 64'(mem_cs), 64'd0);
    chk("reset_addr", 64'(mem_addr), 64'd0);
    chk("reset_tvalid", 64'(tvalid), 64'd0);
    chk("reset_tdata", 64'(tdata), 64'd0);
    chk("reset_wrap", 64'(wrap), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // First-sample latency and backpressure.
    en = 1'b1;
    tick();
    chk("first_cs", 64'(mem_cs), 64'd1);
    chk("first_addr", 64'(mem_addr), 64'd0);
    tick();
    chk("capt_cs", 64'(mem_cs), 64'd0);
    chk("capt_tvalid", 64'(tvalid), 64'd0);
    tick();
    chk("first_tvalid", 64'(tvalid), 64'd1);
    chk("first_tdata", 64'(tdata), 64'hA000);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold", {31'd0, tvalid, mem_cs, wrap, tdata}, {31'd0, 1'b1, 1'b0, 1'b0, 32'hA000});
    end
    tready = 1'b1;
    #1;
    chk("bp_release_wrap", 64'(wrap), 64'd0);
    tick();
    chk("bp_next_cs", 64'(mem_cs), 64'd1);
    chk("bp_next_addr", 64'(mem_addr), 64'd4);
    chk("bp_drop_tvalid", 64'(tvalid), 64'd0);
    en = 1'b0;
    tick(); tick();

    // Table of configurations, checked through the scoreboard.
    foreach (vecs[v]) begin
      start_val = vecs[v].start; end_val = vecs[v].endv; inc_val = vecs[v].inc;
      for (int k = 0; k < 5; k++) addr_exp.push_back(vecs[v].a[k]);
      for (int k = 0; k < 4; k++) begin
        s.data = 32'hA000 + 32'(vecs[v].a[k]);
        s.wrap = vecs[v].w[k];
        samp_exp.push_back(s);
      end
      cyc = 0; last_hs = 0; nhs = 0;
      en = 1'b1; tready = 1'b1;
      while ((addr_exp.size() > 0 || samp_exp.size() > 0) && cyc < 60) begin
        tick();
        cyc++;
        mon();
      end
      if (addr_exp.size() > 0 || samp_exp.size() > 0) begin
        fail("vector_timeout");
        addr_exp.delete();
        samp_exp.delete();
      end
      en = 1'b0;
      tick(); mon();
      tick(); mon();
    end

    // Disable during the wrapping handshake: no wrap pulse, restart at START.
    start_val = 16'd0; end_val = 16'd8; inc_val = 8'd4;
    en = 1'b1; tready = 1'b1;
    cyc = 0;
    while (!(tvalid && tdata == 32'hA008) && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("dis_reach_a008", 64'(tdata), 64'hA008);
    en = 1'b0;
    #1;
    chk("dis_no_wrap", 64'(wrap), 64'd0);
    tick();
    chk("dis_idle", {61'd0, tvalid, mem_cs, wrap}, 64'd0);
    tick();
    chk("dis_idle2", {61'd0, tvalid, mem_cs, wrap}, 64'd0);
    en = 1'b1;
    tick();
    chk("reen_cs", 64'(mem_cs), 64'd1);
    chk("reen_addr", 64'(mem_addr), 64'd0);
    tick(); tick();
    chk("reen_tdata", {31'd0, tvalid, tdata}, {31'd0, 1'b1, 32'hA000});

    // Asynchronous reset between edges during a read.
    en = 1'b0;
    tick(); tick();
    start_val = 16'd3; end_val = 16'd10; inc_val = 8'd1;
    en = 1'b1;
    tick();
    chk("rst_pre_cs", 64'(mem_cs), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", {30'd0, mem_cs, tvalid, wrap, mem_addr, 1'b0, tdata[15:0]}, 64'd0);
    chk("rst_tdata", 64'(tdata), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("rst_restart_cs", 64'(mem_cs), 64'd1);
    chk("rst_restart_addr", 64'(mem_addr), 64'd3);
    tick(); tick();
    chk("rst_restart_tdata", {31'd0, tvalid, tdata}, {31'd0, 1'b1, 32'hA003});
    en = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
